cntr_period_ctrl: RTL

CNTR_PERIOD_CTRL -- requirements
Module: cntr_period_ctrl

---
 rtl/cntr_period_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cntr_period_ctrl.sv
// rtl/cntr_period_ctrl.sv - period sequencer driving an external 4-bit loadable counter
module cntr_period_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [3:0] preset,
    input  logic [3:0] reps,
    input  logic [3:0] count_in,
    input  logic       carry_in,
    output logic       load,
    output logic       cnt_en,
    output logic [3:0] I,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic [7:0] period_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] preset_q;
    logic [3:0] reps_q;
    logic [3:0] remaining;
    logic       mode_q;
    logic       first_run;
    logic       accept;
    logic       period_done;

    // start is only taken from IDLE, and a simultaneous stop vetoes it
    assign accept      = (state == S_IDLE) && start && !stop;
    // stop wins over a terminal count in the same cycle
    assign period_done = (state == S_RUN) && carry_in && !stop;
    assign I           = preset_q;

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (carry_in && !mode_q && (remaining == 4'd0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // outputs; the reload strobe follows carry_in combinationally so periods abut
    always_comb begin
        load   = 1'b0;
        cnt_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            S_LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                busy   = 1'b1;
                load   = period_done && (mode_q || (remaining != 4'd0));
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // run parameters, period bookkeeping and the sticky load check
    always_ff @(posedge clk) begin
        if (!rstn) begin
            preset_q   <= 4'h0;
            reps_q     <= 4'h0;
            remaining  <= 4'h0;
            mode_q     <= 1'b0;
            period_cnt <= 8'h00;
            err        <= 1'b0;
            tick       <= 1'b0;
            first_run  <= 1'b0;
        end else begin
            tick      <= period_done;
            first_run <= (state == S_LOAD) && !stop;
            if (accept) begin
                preset_q   <= preset;
                reps_q     <= reps;
                mode_q     <= mode;
                period_cnt <= 8'h00;
                err        <= 1'b0;
            end else begin
                if (state == S_LOAD) begin
                    remaining <= reps_q;
                end
                // counter did not take the load value on the LOAD edge
                if (first_run && (count_in != preset_q)) begin
                    err <= 1'b1;
                end
                if (period_done) begin
                    if (period_cnt != 8'hFF) begin
                        period_cnt <= period_cnt + 8'd1;
                    end
                    if (!mode_q && (remaining != 4'd0)) begin
                        remaining <= remaining - 4'd1;
                    end
                end
            end
        end
    end

endmodule
